// File: rtl/mmio_timer_core.sv
// Slot-0 MMIO timer: prescaled up-counter with a 32-bit compare, auto-reload,
// sticky expired flag and a level IRQ, behind a three-state slot access FSM.
module mmio_timer_core #(
    parameter int COUNT_W = 48
) (
    input  logic        aclk,
    input  logic        arst_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  reg_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        wr_done,
    output logic        rd_done,
    output logic        idle,
    output logic        slave_error,
    output logic        decode_error,
    output logic        irq
);

    localparam int HI_W = COUNT_W - 32;
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    typedef enum logic [1:0] {IDLE, WR_COMMIT, RELEASE} state_e;

    state_e              state_q, state_d;
    logic [7:0]          addr_q, addr_d;
    logic                wr_ok_q, wr_ok_d;
    logic                dec_q, dec_d, slv_q, slv_d;
    logic                rd_done_q, rd_done_d, wr_done_q, wr_done_d;
    logic [31:0]         rd_data_q, rd_data_d;
    logic                en_q, en_d, ar_q, ar_d, ie_q, ie_d;
    logic [31:0]         cmp_q, cmp_d;
    logic [15:0]         presc_q, presc_d, psc_q, psc_d;
    logic [COUNT_W-1:0]  cnt_q, cnt_d;
    logic [HI_W-1:0]     hi_q, hi_d;
    logic                exp_q, exp_d;

    logic        addr_ok, addr_ro, snap_ld, commit;
    logic        wr_ctrl, wr_stat, wr_cmp, wr_presc;
    logic        tick, match, clr, hit;
    logic [31:0] rd_val;

    assign addr_ok = (reg_addr[1:0] == 2'b00) && (reg_addr <= 8'h14);
    assign addr_ro = (reg_addr == 8'h10) || (reg_addr == 8'h14);

    always_comb begin
        rd_val = '0;
        case (reg_addr[4:2])
            3'd0:    rd_val = {28'd0, ie_q, ar_q, 1'b0, en_q};
            3'd1:    rd_val = {31'd0, exp_q};
            3'd2:    rd_val = cmp_q;
            3'd3:    rd_val = {16'd0, presc_q};
            3'd4:    rd_val = cnt_q[31:0];
            3'd5:    rd_val = 32'(hi_q);
            default: rd_val = '0;
        endcase
    end

    // Access FSM: errors are decided at accept time and held until the next accept.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_ok_d   = wr_ok_q;
        dec_d     = dec_q;
        slv_d     = slv_q;
        rd_done_d = 1'b0;
        wr_done_d = 1'b0;
        rd_data_d = rd_data_q;
        snap_ld   = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs && write) begin
                    addr_d  = reg_addr;
                    dec_d   = !addr_ok;
                    slv_d   = addr_ok && addr_ro;
                    wr_ok_d = addr_ok && !addr_ro;
                    state_d = WR_COMMIT;
                end else if (cs && read) begin
                    dec_d     = !addr_ok;
                    slv_d     = 1'b0;
                    rd_data_d = addr_ok ? rd_val : 32'd0;
                    snap_ld   = addr_ok && (reg_addr == 8'h10);
                    rd_done_d = 1'b1;
                    state_d   = RELEASE;
                end
            end
            WR_COMMIT: begin
                commit    = wr_ok_q;
                wr_done_d = 1'b1;
                state_d   = RELEASE;
            end
            RELEASE: begin
                if (!(cs && (read || write))) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_ctrl  = commit && (addr_q == 8'h00);
    assign wr_stat  = commit && (addr_q == 8'h04);
    assign wr_cmp   = commit && (addr_q == 8'h08);
    assign wr_presc = commit && (addr_q == 8'h0C);

    always_comb begin
        en_d    = en_q;
        ar_d    = ar_q;
        ie_d    = ie_q;
        cmp_d   = cmp_q;
        presc_d = presc_q;
        hi_d    = hi_q;
        if (wr_ctrl) begin
            en_d = wr_data[0];
            ar_d = wr_data[2];
            ie_d = wr_data[3];
        end
        if (wr_cmp)   cmp_d   = wr_data;
        if (wr_presc) presc_d = wr_data[15:0];
        if (snap_ld)  hi_d    = cnt_q[COUNT_W-1:32];
    end

    // Counter: a clear wins over a tick; a same-cycle expire wins over the W1C.
    assign tick  = en_q && (psc_q == presc_q);
    assign match = (cnt_q[31:0] + 32'd1) == cmp_q;
    assign clr   = wr_ctrl && wr_data[1];
    assign hit   = tick && match && !clr;

    always_comb begin
        psc_d = psc_q;
        cnt_d = cnt_q;
        exp_d = exp_q;
        if (en_q) begin
            psc_d = tick ? 16'd0 : psc_q + 16'd1;
            if (tick) cnt_d = (match && ar_q) ? '0 : cnt_q + CNT_ONE;
        end
        if (wr_presc) psc_d = 16'd0;
        if (clr) begin
            psc_d = 16'd0;
            cnt_d = '0;
        end
        if (wr_stat && wr_data[0]) exp_d = 1'b0;
        if (hit) exp_d = 1'b1;
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_ok_q   <= 1'b0;
            dec_q     <= 1'b0;
            slv_q     <= 1'b0;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
            rd_data_q <= '0;
            en_q      <= 1'b0;
            ar_q      <= 1'b0;
            ie_q      <= 1'b0;
            cmp_q     <= '0;
            presc_q   <= '0;
            psc_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            exp_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_ok_q   <= wr_ok_d;
            dec_q     <= dec_d;
            slv_q     <= slv_d;
            rd_done_q <= rd_done_d;
            wr_done_q <= wr_done_d;
            rd_data_q <= rd_data_d;
            en_q      <= en_d;
            ar_q      <= ar_d;
            ie_q      <= ie_d;
            cmp_q     <= cmp_d;
            presc_q   <= presc_d;
            psc_q     <= psc_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            exp_q     <= exp_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_done      = rd_done_q;
    assign wr_done      = wr_done_q;
    assign decode_error = dec_q;
    assign slave_error  = slv_q;
    assign idle         = (state_q == IDLE);
    assign irq          = exp_q && ie_q;

endmodule

// File: tb/tb_mmio_timer_core.sv
// Scoreboard bench for mmio_timer_core: each access queues its expected completion,
// a monitor pops and compares on every done pulse.
module tb_mmio_timer_core;

    logic        aclk = 1'b0;
    logic        arst_n = 1'b0;
    logic        cs = 1'b0, read = 1'b0, write = 1'b0;
    logic [7:0]  reg_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        wr_done, rd_done, idle, slave_error, decode_error, irq;

    mmio_timer_core #(.COUNT_W(48)) dut (
        .aclk(aclk), .arst_n(arst_n), .cs(cs), .read(read), .write(write),
        .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data),
        .wr_done(wr_done), .rd_done(rd_done), .idle(idle),
        .slave_error(slave_error), .decode_error(decode_error), .irq(irq)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        bit          is_rd;
        logic [7:0]  addr;
        logic [31:0] data;
        bit          dec;
        bit          slv;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge aclk) begin
        #1;
        if (rd_done || wr_done) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_done", 64'({rd_done, wr_done}), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val($sformatf("done_kind@%h", mon_e.addr), 64'({rd_done, wr_done}),
                          mon_e.is_rd ? 64'd2 : 64'd1);
                check_val($sformatf("latency@%h", mon_e.addr), 64'(cyc), 64'(mon_e.cyc));
                if (mon_e.is_rd)
                    check_val($sformatf("rd_data@%h", mon_e.addr), 64'(rd_data), 64'(mon_e.data));
                check_val($sformatf("decode_error@%h", mon_e.addr), 64'(decode_error), 64'(mon_e.dec));
                check_val($sformatf("slave_error@%h", mon_e.addr), 64'(slave_error), 64'(mon_e.slv));
            end
        end
    end

    task automatic push_exp(input bit is_rd, input logic [7:0] a, input logic [31:0] d,
                            input bit dec, input bit slv, input int lat);
        exp_t e;
        e.is_rd = is_rd;
        e.addr  = a;
        e.data  = d;
        e.dec   = dec;
        e.slv   = slv;
        e.cyc   = cyc + lat;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        check_val("drain", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    // Tasks start and end on a falling edge.
    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input bit dec, input bit slv);
        cs = 1'b1; read = 1'b1; reg_addr = a;
        push_exp(1'b1, a, exp, dec, slv, 1);
        @(negedge aclk);
        cs = 1'b0; read = 1'b0;
        @(negedge aclk);
        drain();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input bit dec, input bit slv,
                      input bit also_rd);
        cs = 1'b1; write = 1'b1; read = also_rd; reg_addr = a; wr_data = 32'hDEAD_BEEF;
        push_exp(1'b0, a, 32'd0, dec, slv, 2);
        @(negedge aclk);
        cs = 1'b0; write = 1'b0; read = 1'b0; wr_data = d;
        @(negedge aclk);
        wr_data = 32'hDEAD_BEEF;
        @(negedge aclk);
        drain();
    endtask

    initial begin
        repeat (3) @(negedge aclk);
        check_val("rst_rd_data", 64'(rd_data), 64'd0);
        check_val("rst_dones", 64'({rd_done, wr_done}), 64'd0);
        check_val("rst_idle", 64'(idle), 64'd1);
        check_val("rst_errors", 64'({decode_error, slave_error}), 64'd0);
        check_val("rst_irq", 64'(irq), 64'd0);
        arst_n = 1'b1;
        @(negedge aclk);

        // Reads after reset
        rd(8'h00, 32'd0, 1'b0, 1'b0);
        rd(8'h04, 32'd0, 1'b0, 1'b0);
        rd(8'h10, 32'd0, 1'b0, 1'b0);
        check_val("idle_after_reads", 64'(idle), 64'd1);

        // Compare with auto-reload, PRESC=0
        wr(8'h08, 32'd5, 1'b0, 1'b0, 1'b0);
        wr(8'h0C, 32'd0, 1'b0, 1'b0, 1'b0);
        wr(8'h00, 32'h0D, 1'b0, 1'b0, 1'b0);
        rd(8'h10, 32'd1, 1'b0, 1'b0);
        rd(8'h10, 32'd3, 1'b0, 1'b0);
        rd(8'h10, 32'd0, 1'b0, 1'b0);
        rd(8'h04, 32'd1, 1'b0, 1'b0);
        check_val("irq_set", 64'(irq), 64'd1);
        wr(8'h04, 32'd1, 1'b0, 1'b0, 1'b0);
        check_val("irq_w1c", 64'(irq), 64'd0);
        wr(8'h00, 32'h02, 1'b0, 1'b0, 1'b0);
        rd(8'h04, 32'd0, 1'b0, 1'b0);
        rd(8'h10, 32'd0, 1'b0, 1'b0);
        rd(8'h00, 32'd0, 1'b0, 1'b0);
        rd(8'h08, 32'd5, 1'b0, 1'b0);

        // Prescaler of 3 and clear
        wr(8'h0C, 32'd3, 1'b0, 1'b0, 1'b0);
        wr(8'h00, 32'h01, 1'b0, 1'b0, 1'b0);
        rd(8'h10, 32'd0, 1'b0, 1'b0);
        rd(8'h10, 32'd0, 1'b0, 1'b0);
        rd(8'h10, 32'd1, 1'b0, 1'b0);
        rd(8'h10, 32'd1, 1'b0, 1'b0);
        rd(8'h10, 32'd2, 1'b0, 1'b0);
        wr(8'h00, 32'h03, 1'b0, 1'b0, 1'b0);
        rd(8'h00, 32'h01, 1'b0, 1'b0);
        rd(8'h10, 32'd0, 1'b0, 1'b0);
        rd(8'h10, 32'd1, 1'b0, 1'b0);
        wr(8'h00, 32'h02, 1'b0, 1'b0, 1'b0);

        // High-word snapshot
        force dut.cnt_q = 48'h1_0000_0007;
        rd(8'h10, 32'h7, 1'b0, 1'b0);
        force dut.cnt_q = 48'h2_0000_0009;
        rd(8'h14, 32'h1, 1'b0, 1'b0);
        rd(8'h10, 32'h9, 1'b0, 1'b0);
        rd(8'h14, 32'h2, 1'b0, 1'b0);
        release dut.cnt_q;
        wr(8'h00, 32'h02, 1'b0, 1'b0, 1'b0);

        // Error handling
        rd(8'h18, 32'd0, 1'b1, 1'b0);
        check_val("decode_error_held", 64'(decode_error), 64'd1);
        wr(8'h02, 32'h01, 1'b1, 1'b0, 1'b0);
        rd(8'h00, 32'd0, 1'b0, 1'b0);
        wr(8'h10, 32'hFFFF, 1'b0, 1'b1, 1'b0);
        check_val("slave_error_held", 64'(slave_error), 64'd1);
        rd(8'h10, 32'd0, 1'b0, 1'b0);
        rd(8'h01, 32'd0, 1'b1, 1'b0);
        wr(8'h14, 32'd5, 1'b0, 1'b1, 1'b0);
        rd(8'h0C, 32'd3, 1'b0, 1'b0);

        // Held read strobe gives a single acknowledge
        cs = 1'b1; read = 1'b1; reg_addr = 8'h08;
        push_exp(1'b1, 8'h08, 32'd5, 1'b0, 1'b0, 1);
        repeat (3) @(negedge aclk);
        check_val("idle_in_release", 64'(idle), 64'd0);
        cs = 1'b0; read = 1'b0;
        @(negedge aclk);
        check_val("idle_after_release", 64'(idle), 64'd1);
        drain();

        // Read and write together: write wins
        wr(8'h08, 32'd9, 1'b0, 1'b0, 1'b1);
        rd(8'h08, 32'd9, 1'b0, 1'b0);

        // Reset during WR_COMMIT aborts the write
        cs = 1'b1; write = 1'b1; reg_addr = 8'h08; wr_data = 32'hDEAD_BEEF;
        @(negedge aclk);
        cs = 1'b0; write = 1'b0; wr_data = 32'h77;
        check_val("idle_in_commit", 64'(idle), 64'd0);
        arst_n = 1'b0;
        @(negedge aclk);
        arst_n = 1'b1; wr_data = 32'd0;
        @(negedge aclk);
        check_val("idle_after_abort", 64'(idle), 64'd1);
        check_val("no_wr_done_after_abort", 64'(wr_done), 64'd0);
        rd(8'h08, 32'd0, 1'b0, 1'b0);
        check_val("irq_after_abort", 64'(irq), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
